// File: rtl/truth_table_sweeper_if.sv
// Control/status bundle between a sweep controller, the sweeper and the function block.
// The master side drives start/abort/expected and returns f; the slave is the sweeper.
interface truth_table_sweeper_if;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        f;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;
  logic        fail_seen;
  logic [3:0]  first_fail_idx;

  modport master (
    output start, abort, expected, f,
    input  a, b, c, d, busy, done, pass, table_out, mismatch_count, fail_seen, first_fail_idx
  );

  modport slave (
    input  start, abort, expected, f,
    output a, b, c, d, busy, done, pass, table_out, mismatch_count, fail_seen, first_fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input function block through vectors 0..15, holding each HOLD_CYCLES cycles,
// and captures the sampled truth table against a latched expected mask.
//
// state  | meaning
// S_IDLE | outputs parked at 0, waiting for start
// S_RUN  | presenting vector idx, sampling f at the end of each hold
// S_DONE | sweep complete, results frozen until the next start
module truth_table_sweeper #(
  parameter  int HOLD_CYCLES = 20,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       exp_q, exp_d;
  logic [15:0]       table_q, table_d;
  logic [4:0]        mm_q, mm_d;
  logic              fail_q, fail_d;
  logic [3:0]        ffi_q, ffi_d;
  logic              hold_tc;

  assign hold_tc = (cnt_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      exp_q   <= 16'h0000;
      table_q <= 16'h0000;
      mm_q    <= 5'd0;
      fail_q  <= 1'b0;
      ffi_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mm_q    <= mm_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    mm_d    = mm_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = 4'd0;
          cnt_d   = '0;
          exp_d   = bus.expected;
          table_d = 16'h0000;
          mm_d    = 5'd0;
          fail_d  = 1'b0;
          ffi_d   = 4'd0;
        end
      end

      S_RUN: begin
        // abort discards any sample that would have landed on this edge
        if (bus.abort) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
          cnt_d   = '0;
        end else if (hold_tc) begin
          table_d[idx_q] = bus.f;
          if (bus.f != exp_q[idx_q]) begin
            mm_d = mm_q + 5'd1;
            if (!fail_q) begin
              fail_d = 1'b1;
              ffi_d  = idx_q;
            end
          end
          cnt_d = '0;
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  logic [3:0] vec;
  assign vec = (state_q == S_RUN) ? idx_q : 4'd0;

  assign bus.a              = vec[3];
  assign bus.b              = vec[2];
  assign bus.c              = vec[1];
  assign bus.d              = vec[0];
  assign bus.busy           = (state_q == S_RUN);
  assign bus.done           = (state_q == S_DONE);
  assign bus.pass           = (state_q == S_DONE) && (mm_q == 5'd0);
  assign bus.table_out      = table_q;
  assign bus.mismatch_count = mm_q;
  assign bus.fail_seen      = fail_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a HOLD_CYCLES=20 and a HOLD_CYCLES=1 instance,
// scoreboard of expected sweep results popped whenever a sweep reaches DONE.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  logic fsel;

  always #5 clk = ~clk;

  truth_table_sweeper_if if20();
  truth_table_sweeper_if if1();

  truth_table_sweeper #(.HOLD_CYCLES(20)) dut20 (.clk(clk), .rst_n(rst_n), .bus(if20.slave));
  truth_table_sweeper #(.HOLD_CYCLES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  function automatic logic f_model(input logic sel, input logic [3:0] v);
    return sel ? (v[3] & v[2]) : ^v;
  endfunction

  wire [3:0] v20 = {if20.a, if20.b, if20.c, if20.d};
  wire [3:0] v1  = {if1.a, if1.b, if1.c, if1.d};

  assign if20.f = f_model(fsel, v20);
  assign if1.f  = f_model(1'b0, v1);

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  mm;
    logic        fail;
    logic [3:0]  ffi;
    logic        pass;
  } res_t;

  res_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic res_t model(input logic sel, input logic [15:0] exp);
    res_t r;
    r.tbl = 16'h0000; r.mm = 5'd0; r.fail = 1'b0; r.ffi = 4'd0;
    for (int k = 0; k < 16; k++) begin
      r.tbl[k] = f_model(sel, 4'(k));
      if (r.tbl[k] != exp[k]) begin
        r.mm++;
        if (!r.fail) begin
          r.fail = 1'b1;
          r.ffi  = 4'(k);
        end
      end
    end
    r.pass = (r.mm == 5'd0);
    return r;
  endfunction

  task automatic pop_check(input string tag, input logic [15:0] tbl, input logic [4:0] mm,
                           input logic fail, input logic [3:0] ffi, input logic pass);
    res_t r;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      r = sb_q.pop_front();
      check({tag, "_table"}, 32'(tbl),  32'(r.tbl));
      check({tag, "_mm"},    32'(mm),   32'(r.mm));
      check({tag, "_fail"},  32'(fail), 32'(r.fail));
      if (r.fail) check({tag, "_ffi"}, 32'(ffi), 32'(r.ffi));
      check({tag, "_pass"},  32'(pass), 32'(r.pass));
    end
  endtask

  task automatic launch20(input logic sel, input logic [15:0] exp);
    fsel = sel;
    if20.expected = exp;
    @(negedge clk);
    if20.start = 1'b1;
    @(posedge clk);
    #1;
    if20.start = 1'b0;
    if20.expected = ~exp;
  endtask

  task automatic sweep20(input string tag, input logic sel, input logic [15:0] exp);
    sb_q.push_back(model(sel, exp));
    launch20(sel, exp);
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (i % 20 == 0 || i % 20 == 19) check({tag, "_vec"}, 32'(v20), 32'(i / 20));
      if (i == 319) begin
        check({tag, "_busy_last"}, 32'(if20.busy), 32'd1);
        check({tag, "_done_early"}, 32'(if20.done), 32'd0);
      end
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(if20.done), 32'd1);
    check({tag, "_busy"}, 32'(if20.busy), 32'd0);
    check({tag, "_vec_idle"}, 32'(v20), 32'd0);
    pop_check(tag, if20.table_out, if20.mismatch_count, if20.fail_seen,
              if20.first_fail_idx, if20.pass);
  endtask

  task automatic check_reset20(input string tag);
    check({tag, "_busy"},  32'(if20.busy), 32'd0);
    check({tag, "_done"},  32'(if20.done), 32'd0);
    check({tag, "_pass"},  32'(if20.pass), 32'd0);
    check({tag, "_vec"},   32'(v20), 32'd0);
    check({tag, "_table"}, 32'(if20.table_out), 32'd0);
    check({tag, "_mm"},    32'(if20.mismatch_count), 32'd0);
    check({tag, "_fail"},  32'(if20.fail_seen), 32'd0);
    check({tag, "_ffi"},   32'(if20.first_fail_idx), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    fsel  = 1'b0;
    if20.start = 1'b0; if20.abort = 1'b0; if20.expected = 16'h0000;
    if1.start  = 1'b0; if1.abort  = 1'b0; if1.expected  = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset20("rst");
    check("rst1_busy", 32'(if1.busy), 32'd0);

    sweep20("xor_ok", 1'b0, 16'h6996);

    // abort while in DONE has no effect
    @(negedge clk);
    if20.abort = 1'b1;
    @(posedge clk);
    #1;
    if20.abort = 1'b0;
    @(negedge clk);
    check("abort_done_done", 32'(if20.done), 32'd1);
    check("abort_done_pass", 32'(if20.pass), 32'd1);

    sweep20("xor_bad0", 1'b0, 16'h6997);
    sweep20("and_zero", 1'b1, 16'h0000);

    // abort (together with start) sampled at edge E0+101, after bit 4 was captured
    launch20(1'b0, 16'h6997);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    if20.abort = 1'b1;
    if20.start = 1'b1;
    @(posedge clk);
    #1;
    if20.abort = 1'b0;
    if20.start = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(if20.busy), 32'd0);
    check("abort_done",  32'(if20.done), 32'd0);
    check("abort_pass",  32'(if20.pass), 32'd0);
    check("abort_vec",   32'(v20), 32'd0);
    check("abort_table", 32'(if20.table_out), 32'h0016);
    check("abort_mm",    32'(if20.mismatch_count), 32'd1);
    check("abort_fail",  32'(if20.fail_seen), 32'd1);
    sweep20("after_abort", 1'b0, 16'h6996);

    // synchronous reset mid-sweep at idx=7, with start held during reset
    launch20(1'b0, 16'h6997);
    for (int i = 0; i < 145; i++) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    check("pre_rst_vec", 32'(v20), 32'd7);
    rst_n = 1'b0;
    if20.start = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if20.start = 1'b0;
    @(negedge clk);
    check_reset20("mid_rst");

    // HOLD_CYCLES=1 with start held high: back-to-back sweeps, one DONE cycle between
    if1.expected = 16'h6997;
    sb_q.push_back(model(1'b0, 16'h6997));
    @(negedge clk);
    if1.start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("h1_vec", 32'(v1), 32'(i));
      @(posedge clk);
    end
    @(negedge clk);
    check("h1_done", 32'(if1.done), 32'd1);
    check("h1_busy", 32'(if1.busy), 32'd0);
    pop_check("h1_first", if1.table_out, if1.mismatch_count, if1.fail_seen,
              if1.first_fail_idx, if1.pass);
    if1.expected = 16'h6996;
    sb_q.push_back(model(1'b0, 16'h6996));
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("h1_restart_busy",  32'(if1.busy), 32'd1);
        check("h1_restart_done",  32'(if1.done), 32'd0);
        check("h1_restart_table", 32'(if1.table_out), 32'd0);
        check("h1_restart_mm",    32'(if1.mismatch_count), 32'd0);
        check("h1_restart_fail",  32'(if1.fail_seen), 32'd0);
      end
      check("h1_vec2", 32'(v1), 32'(i));
      @(posedge clk);
    end
    @(negedge clk);
    check("h1_done2", 32'(if1.done), 32'd1);
    pop_check("h1_second", if1.table_out, if1.mismatch_count, if1.fail_seen,
              if1.first_fail_idx, if1.pass);
    if1.start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("h1_stays_done", 32'(if1.done), 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that exhaustively drives a 4-input combinational function block (inputs a, b, c, d; output f) through all 16 input combinations in ascending order. It holds each vector for a programmable number of cycles and samples f at the end of each hold. It builds the 16-bit truth table and compares it against an expected mask. It sits between a control/status interface and the function block under exercise, replacing manual vector sequencing.

Parameters:
HOLD_CYCLES, 20, cycles each input vector is held before f is sampled; legal range >= 1
CNT_W, $clog2(HOLD_CYCLES+1), width of the internal hold counter; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a sweep; accepted in IDLE or DONE only, ignored while busy
abort  in  1  cancel an in-progress sweep
expected  in  16  expected truth table, bit k = f for vector k; latched on accepted start
f  in  1  output of the function block under exercise
a  out  1  vector bit 3 (MSB)
b  out  1  vector bit 2
c  out  1  vector bit 1
d  out  1  vector bit 0 (LSB)
busy  out  1  sweep in progress
done  out  1  sweep completed; level, held in DONE
pass  out  1  done and zero mismatches
table_out  out  16  captured truth table, bit k = sampled f for vector k
mismatch_count  out  5  number of bits where table_out != latched expected (0..16)
fail_seen  out  1  at least one mismatch recorded
first_fail_idx  out  4  lowest vector index that mismatched; valid when fail_seen

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; {a,b,c,d}=0; busy=0; done=0; pass=0; table_out=0; mismatch_count=0; fail_seen=0; first_fail_idx=0; idx=0; hold counter=0; expected copy=0. Reset overrides start and abort in the same cycle. Reset mid-sweep aborts with no residue.
- States:
  - IDLE: a..d=0, busy=0, done=0.
  - RUN: busy=1, {a,b,c,d}=idx.
  - DONE: done=1, busy=0, a..d=0.
- Start accepted (start=1 in IDLE/DONE) at edge E0:
  - next state RUN; idx=0; counter=0.
  - Latch expected; clear table_out, mismatch_count, fail_seen, first_fail_idx, done, pass.
- Hold: in RUN the counter increments each cycle. Vector k is presented from edge E0+k*HOLD_CYCLES through edge E0+(k+1)*HOLD_CYCLES, which is exactly HOLD_CYCLES cycles.
- Sample: at edge E0+(k+1)*HOLD_CYCLES:
  - table_out[k] <= f.
  - If f != expected[k]: mismatch_count increments. If fail_seen was 0, set first_fail_idx=k and fail_seen=1.
  - Counter resets to 0; idx increments.
- Completion: the sample of idx=15 moves RUN->DONE at the same edge (E0+16*HOLD_CYCLES). done=1 and pass=(final mismatch_count==0) are visible in the next cycle. No idx wrap ever occurs in RUN.
- HOLD_CYCLES=1: a new vector every cycle, sample each edge; total sweep is 16 cycles.
- abort=1 in RUN:
  - next state IDLE; a..d=0; busy=0; done=0; pass=0.
  - table_out and mismatch fields keep the partial values.
  - abort and start asserted together in RUN: abort wins.
  - abort in IDLE/DONE: no effect.
- start=1 in DONE: restarts per the start rules, with the same-edge clear. start held high continuously re-launches a sweep immediately after each DONE (one DONE cycle between sweeps).
- Changes on expected during RUN are ignored; only the latched copy is used.
- mismatch_count saturates naturally at 16; it needs 5 bits, no overflow possible.

Test Plan:
- HOLD_CYCLES=20, f=a^b^c^d, expected=16'h6996, start pulse -> vectors 0..15 each held 20 cycles; done=1 and busy=0 from 320 cycles after start edge; table_out=16'h6996, pass=1, mismatch_count=0, fail_seen=0.
- Same DUT, expected=16'h6997 -> table_out=16'h6996, pass=0, mismatch_count=1, fail_seen=1, first_fail_idx=0.
- f=a&b (table 16'hF000), expected=16'h0000 -> mismatch_count=4, first_fail_idx=12, pass=0.
- abort at cycle 100 of a HOLD_CYCLES=20 sweep -> busy=0, done=0, a..d=0 next cycle; table_out holds bits 0..4 only; then start -> full sweep completes normally.
- rst_n=0 for 1 cycle mid-sweep (idx=7) -> all outputs at reset values next cycle; start ignored while rst_n=0.
- HOLD_CYCLES=1 build, start held high -> done at cycle 16, one DONE cycle, new sweep begins, results cleared on restart edge.
